// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving four processors exclusive access to a two-bank shared RAM.
// Ownership lasts until done/req drop or HOLD_MAX cycles, then a one-cycle turnaround.
module ram_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] bank_sel,
  input  logic [3:0] done,
  output logic [3:0] Selector,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_REL   = 2'd2;
  logic [1:0] r_state, r_ptr, r_owner;
  logic [7:0] r_cnt;
  logic [3:0] r_sel, r_grant;
  logic       r_busy, r_timeout;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off, w_pick;
  logic       w_lim, w_exit, w_to;
  // Rotate requests so the pointer lands on bit 0, then pick the first set bit.
  always_comb begin
    w_dbl  = {req, req};
    w_rot  = 4'(w_dbl >> r_ptr);
    w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    w_pick = r_ptr + w_off;
    w_lim  = r_cnt == 8'(HOLD_MAX - 1);
    w_exit = done[r_owner] | ~req[r_owner] | w_lim;
    w_to   = w_lim & ~done[r_owner] & req[r_owner];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_cnt     <= 8'd0;
      r_sel     <= 4'hF;
      r_grant   <= 4'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (|req) begin
          r_state <= S_GRANT;
          r_owner <= w_pick;
          r_cnt   <= 8'd0;
          r_sel   <= {1'b0, bank_sel[w_pick], w_pick};
          r_grant <= 4'b0001 << w_pick;
          r_busy  <= 1'b1;
        end
        S_GRANT: if (w_exit) begin
          r_state   <= S_REL;
          r_sel     <= 4'hF;
          r_grant   <= 4'd0;
          r_ptr     <= r_owner + 2'd1;
          r_timeout <= w_to;
        end else r_cnt <= r_cnt + 8'd1;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign Selector = r_sel;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign timeout  = r_timeout;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, directed corner sequences and random traffic
// checked against a cycle-level ownership model of the arbiter.
module tb_ram_arbiter;
  localparam int HM = 4;
  logic       clk, rst;
  logic [3:0] req, bank_sel, done;
  logic [3:0] Selector, grant;
  logic       busy, timeout;
  int n_cmp = 0, n_bad = 0;
  int m_own, m_bank, m_held, m_ptr;
  bit m_rel, m_to;
  typedef struct {
    logic [3:0] req, bank, done, sel, gnt;
    logic       bsy, to;
  } vec_t;
  vec_t tbl[$];

  ram_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .bank_sel(bank_sel), .done(done),
    .Selector(Selector), .grant(grant), .busy(busy), .timeout(timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] es, eg, input logic eb, et);
    n_cmp++;
    if (Selector !== es || grant !== eg || busy !== eb || timeout !== et) begin
      n_bad++;
      $display("FAIL %s: got sel=%h grant=%b busy=%b timeout=%b, want sel=%h grant=%b busy=%b timeout=%b",
               nm, Selector, grant, busy, timeout, es, eg, eb, et);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rel = 0; m_ptr = 0; m_to = 0; m_held = 0; m_bank = 0;
  endtask

  // One clock edge of the arbiter's ownership rules.
  task automatic model_edge();
    m_to = 0;
    if (m_rel) m_rel = 0;
    else if (m_own >= 0) begin
      m_held++;
      if (done[m_own] || !req[m_own] || m_held == HM) begin
        m_to  = (m_held == HM) && !done[m_own] && req[m_own];
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
        m_rel = 1;
      end
    end else if (req != 0) begin
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && req[(m_ptr + k) % 4]) begin
          m_own  = (m_ptr + k) % 4;
          m_bank = bank_sel[m_own];
          m_held = 0;
        end
    end
  endtask

  task automatic step(input string nm, input logic [3:0] r, b, d);
    logic [3:0] es, eg;
    req = r; bank_sel = b; done = d;
    @(posedge clk);
    model_edge();
    #1;
    es = (m_own < 0) ? 4'hF : 4'(m_bank * 4 + m_own);
    eg = (m_own < 0) ? 4'd0 : 4'(1 << m_own);
    chk(nm, es, eg, (m_own >= 0) || m_rel, m_to);
  endtask

  task automatic do_reset();
    #2 rst = 0;
    #1 chk("async_reset", 4'hF, 4'd0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1 chk("reset_hold", 4'hF, 4'd0, 1'b0, 1'b0);
    rst = 1;
  endtask

  initial begin
    rst = 0; req = 0; bank_sel = 0; done = 0;
    model_reset();
    #12 chk("reset_state", 4'hF, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1;
    // round-robin with done pulses
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h0,4'b0001,1,0});
    tbl.push_back('{4'hF,4'h0,4'h1, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'hF,4'b0000,0,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h1,4'b0010,1,0});
    tbl.push_back('{4'hF,4'h0,4'h2, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'hF,4'b0000,0,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h2,4'b0100,1,0});
    tbl.push_back('{4'hF,4'h0,4'h4, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'hF,4'b0000,0,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h3,4'b1000,1,0});
    tbl.push_back('{4'hF,4'h0,4'h8, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'hF,4'b0000,0,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h0,4'b0001,1,0});
    tbl.push_back('{4'hF,4'h0,4'h1, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,0,0});
    // single request on bank 1
    tbl.push_back('{4'h4,4'h4,4'h0, 4'h6,4'b0100,1,0});
    tbl.push_back('{4'h4,4'h4,4'h4, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,0,0});
    // done in IDLE and from non-owners ignored, req drop releases
    tbl.push_back('{4'h1,4'h0,4'h1, 4'h0,4'b0001,1,0});
    tbl.push_back('{4'h1,4'h0,4'hE, 4'h0,4'b0001,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,0,0});
    // hold limit revokes p1, then ptr=2
    tbl.push_back('{4'h2,4'h0,4'h0, 4'h1,4'b0010,1,0});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'h2,4'h0,4'h0, 4'h1,4'b0010,1,0});
    tbl.push_back('{4'h2,4'h0,4'h0, 4'hF,4'b0000,1,1});
    tbl.push_back('{4'h2,4'h0,4'h0, 4'hF,4'b0000,0,0});
    tbl.push_back('{4'hF,4'h0,4'h0, 4'h2,4'b0100,1,0});
    tbl.push_back('{4'hF,4'h0,4'h4, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,0,0});
    // done coincides with the hold limit: no timeout
    tbl.push_back('{4'h1,4'h0,4'h0, 4'h0,4'b0001,1,0});
    for (int i = 0; i < 3; i++) tbl.push_back('{4'h1,4'h0,4'h0, 4'h0,4'b0001,1,0});
    tbl.push_back('{4'h1,4'h0,4'h1, 4'hF,4'b0000,1,0});
    tbl.push_back('{4'h0,4'h0,4'h0, 4'hF,4'b0000,0,0});
    foreach (tbl[i]) begin
      step($sformatf("model_vec%0d", i), tbl[i].req, tbl[i].bank, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].bsy, tbl[i].to);
    end
    // owner p3 keeps its bank while bank_sel and other reqs change
    do_reset();
    step("mid_a", 4'h8, 4'h0, 4'h0); chk("mid_grant_p3", 4'h3, 4'b1000, 1, 0);
    step("mid_b", 4'h9, 4'h8, 4'h0); chk("mid_bank_toggle", 4'h3, 4'b1000, 1, 0);
    step("mid_c", 4'h9, 4'h0, 4'h0); chk("mid_bank_back", 4'h3, 4'b1000, 1, 0);
    step("mid_d", 4'h9, 4'h8, 4'h8); chk("mid_release", 4'hF, 4'd0, 1, 0);
    step("mid_e", 4'h1, 4'h0, 4'h0);
    step("mid_f", 4'h1, 4'h0, 4'h0); chk("mid_next_p0", 4'h0, 4'b0001, 1, 0);
    // async reset between edges while granted
    step("ar_a", 4'h1, 4'h0, 4'h0);
    do_reset();
    step("ar_after", 4'h0, 4'h0, 4'h0); chk("ar_idle", 4'hF, 4'd0, 0, 0);
    step("ar_first", 4'h4, 4'h4, 4'h0); chk("ar_first_grant", 4'h6, 4'b0100, 1, 0);
    for (int i = 0; i < 800; i++) begin
      logic [3:0] r, d;
      r = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step($sformatf("rand%0d", i), r, 4'($urandom), d);
      if (i % 250 == 249) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
